// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: timer state encoding and default width.
package counter_pkg;
    timeunit 1ns;
    timeprecision 100ps;

    localparam int DEFAULT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RUN     = 2'd2,
        EXPIRED = 2'd3
    } timer_state_t;
endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/pause, one-shot or auto-reload, and a registered terminal pulse.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             start,
    input  logic             enable,
    input  logic             reload_en,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             done
);
    timeunit 1ns;
    timeprecision 100ps;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            period_q <= ZERO;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            period_q <= period_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        period_d = period_q;
        done_d   = 1'b0;

        if (load) begin
            // A load overrides everything, including a coincident terminal event.
            count_d  = data;
            period_d = data;
            state_d  = (data != ZERO) ? ARMED : IDLE;
        end else begin
            unique case (state_q)
                IDLE: ;
                ARMED: begin
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (enable) begin
                        if (count_q > ONE) begin
                            count_d = count_q - ONE;
                        end else begin
                            // Terminal edge: reload_en is only looked at here.
                            done_d = 1'b1;
                            if (reload_en) begin
                                count_d = period_q;
                            end else begin
                                count_d = ZERO;
                                state_d = EXPIRED;
                            end
                        end
                    end
                end
                EXPIRED: begin
                    if (start) begin
                        count_d = period_q;
                        state_d = RUN;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign busy    = (state_q == RUN);
    assign expired = (state_q == EXPIRED);

endmodule
